// File: rtl/spike_frame_packer_layer1_pkg.sv
// Shared constants and state encoding for the layer-1 spike frame packer.
// Frame words are 16-bit: header, ascending spike indices, tail.
package spike_frame_packer_layer1_pkg;

    localparam int IDX_W = 16;

    localparam logic [IDX_W-1:0] FRAME_HEAD = 16'hF1FA;
    localparam logic [IDX_W-1:0] FRAME_TAIL = 16'hFAF1;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        SCAN,
        TAIL
    } pack_state_t;

endpackage

// File: rtl/spike_frame_packer_layer1_lowest_set_bit_enc.sv
// Combinational lowest-set-bit finder for one SCAN_W-bit chunk of the bitmap.
// Reports whether any bit is set and the position of the lowest one.
module lowest_set_bit_enc #(
    parameter int SCAN_W = 16,
    parameter int POS_W  = (SCAN_W > 1) ? $clog2(SCAN_W) : 1
) (
    input  logic [SCAN_W-1:0] bits,
    output logic              found,
    output logic [POS_W-1:0]  pos
);

    // Scan from the top down so the lowest set bit is the last assignment made.
    always_comb begin
        found = 1'b0;
        pos   = '0;
        for (int i = SCAN_W - 1; i >= 0; i--) begin
            if (bits[i]) begin
                found = 1'b1;
                pos   = POS_W'(i);
            end
        end
    end

endmodule

// File: rtl/spike_frame_packer_layer1.sv
// Packs one timestep's spike bitmap into a framed 16-bit index stream for the index FIFO.
// Optional macro SPIKE_FRAME_EMPTY_SKIP_EN: an all-zero bitmap emits no frame, only frame_done_o.
module spike_frame_packer_layer1
    import spike_frame_packer_layer1_pkg::*;
#(
    parameter int NUM_IN = 256,
    parameter int SCAN_W = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_IN-1:0] spike_vec_i,
    input  logic              spike_valid_i,
    output logic              spike_ready_o,
    input  logic              fifo_full_i,
    output logic              fifo_w_en_o,
    output logic [IDX_W-1:0]  fifo_w_data_o,
    output logic              frame_done_o,
    output logic              busy_o
);

    localparam int CHUNKS = NUM_IN / SCAN_W;
    localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int POS_W  = (SCAN_W > 1) ? $clog2(SCAN_W) : 1;
    localparam int AW     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    // Indices must never alias the header word, and chunks must tile the bitmap exactly.
    if ((NUM_IN % SCAN_W) != 0 || NUM_IN > 32'hF1FA) begin : g_bad_params
        $error("spike_frame_packer_layer1: NUM_IN must be a multiple of SCAN_W and <= 0xF1FA");
    end

    pack_state_t       state, state_nxt;
    logic [NUM_IN-1:0] work, work_nxt;
    logic [CW-1:0]     c, c_nxt;
    logic              done_nxt;

    logic [SCAN_W-1:0] chunk;
    logic              found;
    logic [POS_W-1:0]  pos;
    logic [AW-1:0]     bit_sel;
    logic [IDX_W-1:0]  spike_idx;

    assign chunk     = work[AW'(int'(c) * SCAN_W) +: SCAN_W];
    assign bit_sel   = AW'(int'(c) * SCAN_W + int'(pos));
    assign spike_idx = IDX_W'(int'(c) * SCAN_W + int'(pos));

    lowest_set_bit_enc #(
        .SCAN_W (SCAN_W),
        .POS_W  (POS_W)
    ) u_lsb (
        .bits  (chunk),
        .found (found),
        .pos   (pos)
    );

    assign spike_ready_o = (state == IDLE);
    assign busy_o        = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= IDLE;
            work         <= '0;
            c            <= '0;
            frame_done_o <= 1'b0;
        end else begin
            state        <= state_nxt;
            work         <= work_nxt;
            c            <= c_nxt;
            frame_done_o <= done_nxt;
        end
    end

    // Write strobe is Mealy on fifo_full_i so a word is only issued when it will be taken.
    always_comb begin
        state_nxt     = state;
        work_nxt      = work;
        c_nxt         = c;
        done_nxt      = 1'b0;
        fifo_w_en_o   = 1'b0;
        fifo_w_data_o = '0;
        case (state)
            IDLE: begin
                if (spike_valid_i) begin
                    work_nxt = spike_vec_i;
                    c_nxt    = '0;
`ifdef SPIKE_FRAME_EMPTY_SKIP_EN
                    if (spike_vec_i == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = HEAD;
                    end
`else
                    state_nxt = HEAD;
`endif
                end
            end
            HEAD: begin
                if (!fifo_full_i) begin
                    fifo_w_en_o   = 1'b1;
                    fifo_w_data_o = FRAME_HEAD;
                    state_nxt     = SCAN;
                end
            end
            SCAN: begin
                if (found) begin
                    if (!fifo_full_i) begin
                        fifo_w_en_o       = 1'b1;
                        fifo_w_data_o     = spike_idx;
                        work_nxt[bit_sel] = 1'b0;
                    end
                end else if (c == CW'(CHUNKS - 1)) begin
                    state_nxt = TAIL;
                end else begin
                    c_nxt = c + CW'(1);
                end
            end
            TAIL: begin
                if (!fifo_full_i) begin
                    fifo_w_en_o   = 1'b1;
                    fifo_w_data_o = FRAME_TAIL;
                    done_nxt      = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spike_frame_packer_layer1.sv
// Self-checking bench for spike_frame_packer_layer1 (NUM_IN=64, SCAN_W=16): directed and random frames
// compared against a queue-based frame model built from the bitmap.
module tb_spike_frame_packer_layer1;

    localparam int NUM_IN = 64;
    localparam int SCAN_W = 16;
    localparam int CHUNKS = NUM_IN / SCAN_W;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NUM_IN-1:0] spike_vec_i = '0;
    logic              spike_valid_i = 1'b0;
    logic              spike_ready_o;
    logic              fifo_full_i = 1'b0;
    logic              fifo_w_en_o;
    logic [15:0]       fifo_w_data_o;
    logic              frame_done_o;
    logic              busy_o;

    int tests_run    = 0;
    int tests_failed = 0;

    spike_frame_packer_layer1 #(
        .NUM_IN (NUM_IN),
        .SCAN_W (SCAN_W)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .spike_vec_i   (spike_vec_i),
        .spike_valid_i (spike_valid_i),
        .spike_ready_o (spike_ready_o),
        .fifo_full_i   (fifo_full_i),
        .fifo_w_en_o   (fifo_w_en_o),
        .fifo_w_data_o (fifo_w_data_o),
        .frame_done_o  (frame_done_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one bitmap in the current cycle and follows the frame until frame_done_o.
    // exp_span: -1 = do not check, 0 = derive 2+N+CHUNKS, >0 = explicit span in cycles.
    task automatic applyStimulus(input string name, input logic [NUM_IN-1:0] vec, input int fs, input int fl,
                                 input bit rand_full, input bit hold_valid, input int exp_span);
        logic [15:0] expq[$];
        logic [15:0] got[$];
        int          first_w = -1;
        int          last_w = -1;
        int          done_cycle = -1;
        int          n = 0;
        int          span = exp_span;
        int          lim;
        bit          proto_ok = 1'b1;

        for (int i = 0; i < NUM_IN; i++) begin
            if (vec[i]) begin
                expq.push_back(16'(i));
                n++;
            end
        end
`ifdef SPIKE_FRAME_EMPTY_SKIP_EN
        if (n != 0) begin
            expq.push_front(16'hF1FA);
            expq.push_back(16'hFAF1);
        end
`else
        expq.push_front(16'hF1FA);
        expq.push_back(16'hFAF1);
`endif
        if (span == 0) span = 2 + n + CHUNKS;

        spike_vec_i   = vec;
        spike_valid_i = 1'b1;
        fifo_full_i   = 1'b0;
        #1;
        checkOutput({name, " ready_at_accept"}, 32'(spike_ready_o), 32'd1);

        for (int k = 1; k <= 400 && done_cycle < 0; k++) begin
            @(negedge clk);
            spike_valid_i = hold_valid;
            spike_vec_i   = {$urandom, $urandom};
            fifo_full_i   = (k >= fs && k < fs + fl) || (rand_full && $urandom_range(0, 3) == 0);
            #1;
            if (fifo_w_en_o && fifo_full_i) proto_ok = 1'b0;
            if (!fifo_w_en_o && fifo_w_data_o !== 16'h0000) proto_ok = 1'b0;
            if (busy_o === spike_ready_o) proto_ok = 1'b0;
            if (fifo_w_en_o) begin
                got.push_back(fifo_w_data_o);
                if (first_w < 0) first_w = k;
                last_w = k;
            end
            if (frame_done_o) done_cycle = k;
            else if (!busy_o) proto_ok = 1'b0;
        end
        fifo_full_i = 1'b0;
        if (!hold_valid) spike_valid_i = 1'b0;

        checkOutput({name, " frame_done_seen"}, 32'(done_cycle > 0), 32'd1);
        checkOutput({name, " word_count"}, 32'(got.size()), 32'(expq.size()));
        lim = (got.size() < expq.size()) ? got.size() : expq.size();
        for (int i = 0; i < lim; i++)
            checkOutput($sformatf("%s word%0d", name, i), 32'(got[i]), 32'(expq[i]));
        if (expq.size() > 0) begin
            checkOutput({name, " done_after_tail"}, 32'(done_cycle), 32'(last_w + 1));
            if (span > 0) begin
                checkOutput({name, " header_latency"}, 32'(first_w), 32'd1);
                checkOutput({name, " frame_span"}, 32'(last_w - first_w + 1), 32'(span));
            end
        end else begin
            checkOutput({name, " skip_done_latency"}, 32'(done_cycle), 32'd1);
        end
        checkOutput({name, " protocol"}, 32'(proto_ok), 32'd1);
    endtask

    initial begin
        logic [NUM_IN-1:0] v;

        #2;
        checkOutput("reset ready", 32'(spike_ready_o), 32'd1);
        checkOutput("reset w_en", 32'(fifo_w_en_o), 32'd0);
        checkOutput("reset data", 32'(fifo_w_data_o), 32'd0);
        checkOutput("reset busy", 32'(busy_o), 32'd0);
        checkOutput("reset done", 32'(frame_done_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        v = '0; v[0] = 1'b1; v[5] = 1'b1; v[63] = 1'b1;
        applyStimulus("bits_0_5_63", v, 0, 0, 1'b0, 1'b0, 9);
        @(negedge clk);
        applyStimulus("backpressure", v, 3, 3, 1'b0, 1'b0, 12);
        @(negedge clk);
        v = '0; v[31:16] = 16'hFFFF;
        applyStimulus("chunk1_full", v, 0, 0, 1'b0, 1'b0, 22);
        @(negedge clk);
        applyStimulus("empty", '0, 0, 0, 1'b0, 1'b0, 6);
        @(negedge clk);

        applyStimulus("b2b_first", {$urandom, $urandom} & {$urandom, $urandom}, 0, 0, 1'b0, 1'b1, 0);
        applyStimulus("b2b_second", {$urandom, $urandom} & {$urandom, $urandom}, 0, 0, 1'b0, 1'b0, 0);

        for (int r = 0; r < 12; r++) begin
            @(negedge clk);
            applyStimulus($sformatf("rand_bp%0d", r), {$urandom, $urandom} & {$urandom, $urandom},
                          0, 0, 1'b1, 1'b0, -1);
        end
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            applyStimulus($sformatf("rand_free%0d", r),
                          {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom},
                          0, 0, 1'b0, 1'b0, 0);
        end

        // Reset lands after the header and two indices have been written.
        @(negedge clk);
        v = '0; v[1] = 1'b1; v[2] = 1'b1; v[3] = 1'b1; v[40] = 1'b1;
        spike_vec_i   = v;
        spike_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            spike_valid_i = 1'b0;
        end
        @(negedge clk);
        rstn = 1'b0;
        #1;
        checkOutput("midreset ready", 32'(spike_ready_o), 32'd1);
        checkOutput("midreset w_en", 32'(fifo_w_en_o), 32'd0);
        checkOutput("midreset data", 32'(fifo_w_data_o), 32'd0);
        checkOutput("midreset busy", 32'(busy_o), 32'd0);
        checkOutput("midreset done", 32'(frame_done_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        applyStimulus("after_reset", {$urandom, $urandom} & {$urandom, $urandom}, 0, 0, 1'b0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
